// File: rtl/ccff_loader.sv
// Configuration-chain loader: streams valid/ready words LSB-first into the ccff chain.
// Optional CRC read-back pass over the whole chain when CCFF_LOADER_VERIFY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; words not accepted
// LOAD   | accepting words and shifting bits into the chain
// VERIFY | rotating the chain through itself, CRC on ccff_tail
// FINISH | one-cycle done pulse
module ccff_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              pReset,
    input  logic              prog_clk,
    input  logic              start,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [WORD_W-1:0] word_data,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = ($clog2(CHAIN_LEN + 1) > $clog2(WORD_W + 1)) ?
                           $clog2(CHAIN_LEN + 1) : $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WORD_W_C    = CNT_W'(WORD_W);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
`ifdef CCFF_LOADER_VERIFY_EN
    localparam logic [1:0] S_VERIFY = 2'd2;
`endif
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]        state;
    logic [WORD_W-1:0] buf_q;
    logic [CNT_W-1:0]  buf_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  take;
    logic              head_q;
    logic              shift_en_q;
    logic              done_q;
    logic              xfer;
    logic              shift;

    // The final word is truncated to the bits the chain still needs.
    assign remaining = CHAIN_LEN_C - acc_cnt;
    assign take      = (remaining < WORD_W_C) ? remaining : WORD_W_C;

    assign word_ready    = (state == S_LOAD) && (buf_cnt <= CNT_W'(1)) && (acc_cnt < CHAIN_LEN_C);
    assign xfer          = word_valid && word_ready;
    assign shift         = (state == S_LOAD) && (buf_cnt != '0);
    assign busy          = (state != S_IDLE);
    assign ccff_shift_en = shift_en_q;
    assign done          = done_q;

`ifdef CCFF_LOADER_VERIFY_EN
    logic [15:0]      crc_wr;
    logic [15:0]      crc_rd;
    logic [15:0]      crc_rd_next;
    logic [CNT_W-1:0] vcnt;
    logic             error_q;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign crc_rd_next = crc_step(crc_rd, ccff_tail);
    // Loopback is combinational so the chain rotates back to its loaded contents.
    assign ccff_head   = (state == S_VERIFY) ? ccff_tail : head_q;
    assign error       = error_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign ccff_head   = head_q;
    assign error       = 1'b0;
`endif

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state      <= S_IDLE;
            buf_q      <= '0;
            buf_cnt    <= '0;
            bit_cnt    <= '0;
            acc_cnt    <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
            crc_wr     <= 16'hFFFF;
            crc_rd     <= 16'hFFFF;
            vcnt       <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            shift_en_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_LOAD;
                        buf_cnt <= '0;
                        bit_cnt <= '0;
                        acc_cnt <= '0;
`ifdef CCFF_LOADER_VERIFY_EN
                        crc_wr  <= 16'hFFFF;
                        crc_rd  <= 16'hFFFF;
                        vcnt    <= '0;
                        error_q <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (shift) begin
                        shift_en_q <= 1'b1;
                        head_q     <= buf_q[0];
                        bit_cnt    <= bit_cnt + CNT_W'(1);
`ifdef CCFF_LOADER_VERIFY_EN
                        crc_wr     <= crc_step(crc_wr, buf_q[0]);
`endif
                    end
                    // A transfer on the last buffered bit keeps the stream gapless.
                    if (xfer) begin
                        buf_q   <= word_data;
                        buf_cnt <= take;
                        acc_cnt <= acc_cnt + take;
                    end else if (shift) begin
                        buf_q   <= buf_q >> 1;
                        buf_cnt <= buf_cnt - CNT_W'(1);
                    end
                    if (bit_cnt == CHAIN_LEN_C) begin
`ifdef CCFF_LOADER_VERIFY_EN
                        state      <= S_VERIFY;
                        shift_en_q <= 1'b1;
                        vcnt       <= '0;
`else
                        state  <= S_FINISH;
                        done_q <= 1'b1;
`endif
                    end
                end
`ifdef CCFF_LOADER_VERIFY_EN
                S_VERIFY: begin
                    crc_rd <= crc_rd_next;
                    if (vcnt == CHAIN_LEN_C - CNT_W'(1)) begin
                        state   <= S_FINISH;
                        done_q  <= 1'b1;
                        error_q <= (crc_rd_next != crc_wr);
                    end else begin
                        shift_en_q <= 1'b1;
                        vcnt       <= vcnt + CNT_W'(1);
                    end
                end
`endif
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader with a 12-bit chain model on ccff_head/ccff_tail.
// Verify-pass checks are compiled in when CCFF_LOADER_VERIFY_EN is defined.
module tb_ccff_loader;

    localparam int CHAIN_LEN = 12;
    localparam int WORD_W    = 8;
    localparam logic [11:0] GOLD = 12'hA5C;
`ifdef CCFF_LOADER_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    logic              pReset;
    logic              prog_clk;
    logic              start;
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;
    logic              ccff_head;
    logic              ccff_tail;
    logic              ccff_shift_en;
    logic              busy;
    logic              done;
    logic              error;

    logic [11:0] chain;
    logic        corrupt;

    int n_tests = 0;
    int n_fail  = 0;

    ccff_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .pReset       (pReset),
        .prog_clk     (prog_clk),
        .start        (start),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_data    (word_data),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .ccff_shift_en(ccff_shift_en),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Chain model: head enters at bit 0, tail leaves from bit 11.
    assign ccff_tail = chain[11] ^ corrupt;
    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {chain[10:0], ccff_head};
    end

    typedef struct {
        logic       start;
        logic       valid;
        logic [7:0] data;
        logic [4:0] exp;   // {word_ready, ccff_head, ccff_shift_en, busy, done}
    } vec_t;

    vec_t vt[16];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 100 && busy; k++) begin
            @(posedge prog_clk); #1;
        end
        check(name, int'(busy), 0);
    endtask

    task automatic run_load(input int gap, input int poke_start, input int corrupt_at,
                            input int abort_at, output int shifts, output int stalls,
                            output int lat, output int dones);
        int  widx;
        int  gap_left;
        int  first;
        int  last;
        int  done_cyc;
        bit  xfer;
        widx = 0; gap_left = gap; first = -1; last = -1; done_cyc = -1;
        shifts = 0; dones = 0;
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (widx < 2 && !(widx == 1 && word_ready && gap_left > 0)) begin
                word_valid = 1'b1;
                word_data  = (widx == 0) ? 8'hA5 : 8'h03;
            end else begin
                word_valid = 1'b0;
                if (widx == 1 && word_ready && gap_left > 0) gap_left--;
            end
            start   = (cyc == poke_start);
            corrupt = (shifts == corrupt_at);
            xfer    = word_valid && word_ready;
            @(posedge prog_clk); #1;
            if (xfer) widx++;
            if (ccff_shift_en) begin
                shifts++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (abort_at > 0 && shifts == abort_at) begin
                pReset = 1'b1;
                #1;
                check("abort_outputs_zero",
                      int'({word_ready, ccff_head, ccff_shift_en, busy, done, error}), 0);
                break;
            end
            if (!busy) break;
        end
        corrupt = 1'b0; word_valid = 1'b0; start = 1'b0;
        stalls = (first < 0) ? -1 : (last - first + 1) - shifts;
        lat    = (first < 0 || done_cyc < 0) ? -1 : done_cyc - first;
        if (abort_at <= 0) check("load_ends_idle", int'(busy), 0);
    endtask

    task automatic check_run(input string tag, input int gap, input int sh, input int st,
                             input int lt, input int dn);
        check({tag, "_shifts"}, sh, (VER + 1) * CHAIN_LEN);
        check({tag, "_stalls"}, st, gap);
        check({tag, "_latency"}, lt, (VER + 1) * CHAIN_LEN + gap);
        check({tag, "_dones"}, dn, 1);
    endtask

    initial begin
        int sh, st, lt, dn;
        int nv;

        vt[0]  = '{1'b1, 1'b0, 8'h00, 5'b10010};
        vt[1]  = '{1'b0, 1'b1, 8'hA5, 5'b00010};
        vt[2]  = '{1'b0, 1'b1, 8'h03, 5'b01110};
        vt[3]  = '{1'b0, 1'b1, 8'h03, 5'b00110};
        vt[4]  = '{1'b0, 1'b1, 8'h03, 5'b01110};
        vt[5]  = '{1'b0, 1'b1, 8'h03, 5'b00110};
        vt[6]  = '{1'b0, 1'b1, 8'h03, 5'b00110};
        vt[7]  = '{1'b0, 1'b1, 8'h03, 5'b01110};
        vt[8]  = '{1'b0, 1'b1, 8'h03, 5'b10110};
        vt[9]  = '{1'b0, 1'b1, 8'h03, 5'b01110};
        vt[10] = '{1'b0, 1'b0, 8'h00, 5'b01110};
        vt[11] = '{1'b0, 1'b0, 8'h00, 5'b01110};
        vt[12] = '{1'b0, 1'b0, 8'h00, 5'b00110};
        vt[13] = '{1'b0, 1'b0, 8'h00, 5'b00110};
        vt[14] = '{1'b0, 1'b0, 8'h00, 5'b00011};
        vt[15] = '{1'b0, 1'b0, 8'h00, 5'b00000};
        nv = (VER != 0) ? 14 : 16;

        pReset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = '0;
        corrupt = 1'b0; chain = '0;
        repeat (3) @(posedge prog_clk);
        #1;
        check("reset_outputs",
              int'({word_ready, ccff_head, ccff_shift_en, busy, done, error}), 0);
        @(negedge prog_clk) pReset = 1'b0;
        @(posedge prog_clk); #1;

        // Back-to-back load, cycle by cycle.
        for (int i = 0; i < nv; i++) begin
            start      = vt[i].start;
            word_valid = vt[i].valid;
            word_data  = vt[i].data;
            @(posedge prog_clk); #1;
            check($sformatf("vec%0d", i),
                  int'({word_ready, ccff_head, ccff_shift_en, busy, done}), int'(vt[i].exp));
            check($sformatf("vec%0d_error", i), int'(error), 0);
        end
        start = 1'b0; word_valid = 1'b0;
        wait_idle("table_idle");
        check("table_chain", int'(chain), int'(GOLD));

        // start pulsed mid-load must be ignored.
        chain = '0;
        run_load(0, 5, -1, 0, sh, st, lt, dn);
        check_run("poke", 0, sh, st, lt, dn);
        check("poke_chain", int'(chain), int'(GOLD));
        check("poke_error", int'(error), 0);

        // Three-cycle gap between words.
        chain = '0;
        run_load(3, -1, -1, 0, sh, st, lt, dn);
        check_run("gap3", 3, sh, st, lt, dn);
        check("gap3_chain", int'(chain), int'(GOLD));

        // Words offered in IDLE are not taken.
        word_valid = 1'b1; word_data = 8'hA5;
        for (int k = 0; k < 5; k++) begin
            @(posedge prog_clk); #1;
            check($sformatf("idle_valid%0d", k),
                  int'({word_ready, ccff_shift_en, busy, done}), 0);
        end
        word_valid = 1'b0;
        check("idle_chain_held", int'(chain), int'(GOLD));

`ifdef CCFF_LOADER_VERIFY_EN
        // One tail bit flipped during the loopback pass.
        run_load(0, -1, 17, 0, sh, st, lt, dn);
        check("corrupt_dones", dn, 1);
        check("corrupt_error", int'(error), 1);
        @(posedge prog_clk); #1;
        check("corrupt_error_sticky", int'(error), 1);
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        check("error_cleared_on_start", int'(error), 0);
        chain = '0;
        run_load(0, -1, -1, 0, sh, st, lt, dn);
        check_run("after_err", 0, sh, st, lt, dn);
        check("after_err_error", int'(error), 0);
        check("after_err_chain", int'(chain), int'(GOLD));
`endif

        // Reset during the 7th shift, then a clean reload.
        chain = '0;
        run_load(0, -1, -1, 7, sh, st, lt, dn);
        check("abort_shifts", sh, 7);
        @(negedge prog_clk) pReset = 1'b0;
        @(posedge prog_clk); #1;
        check("abort_still_idle", int'({busy, word_ready, ccff_shift_en}), 0);
        run_load(0, -1, -1, 0, sh, st, lt, dn);
        check_run("reload", 0, sh, st, lt, dn);
        check("reload_chain", int'(chain), int'(GOLD));
        check("reload_error", int'(error), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
